cam_bank_packer: RTL and testbench



---
 rtl/cam_bank_packer.sv | 184 ++++++++++++++++++
 tb/tb_cam_bank_packer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_bank_packer.sv
// cam_bank_packer: packs qualified sensor pixels into RAM words and
// writes them round-robin into ping-pong banks with full/release flags.
module cam_bank_packer #(
    parameter int PIX_W     = 8,
    parameter int WORD_W    = 32,
    parameter int NUM_BANKS = 4,
    parameter int BANK_AW   = 9
) (
    input  logic                 PCLKI,
    input  logic                 WBs_RST_i,
    input  logic                 VSYNCI,
    input  logic                 HREFI,
    input  logic [PIX_W-1:0]     PIXD_i,
    input  logic                 enable_i,
    input  logic                 mode_i,
    input  logic                 clr_i,
    input  logic [NUM_BANKS-1:0] bank_release_i,
    output logic [BANK_AW-1:0]   wr_addr_o,
    output logic [WORD_W-1:0]    wr_data_o,
    output logic [NUM_BANKS-1:0] wr_en_o,
    output logic [NUM_BANKS-1:0] bank_full_o,
    output logic                 overflow_o,
    output logic [15:0]          frame_cnt_o,
    output logic [11:0]          line_cnt_o,
    output logic [1:0]           state_o
);
    localparam int BYTES = WORD_W / PIX_W;
    localparam int CW = $clog2(BYTES);
    localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int SW = WORD_W - PIX_W;
    localparam logic [CW-1:0] LAST_PIX = CW'(BYTES - 1);
    localparam logic [BW-1:0] LAST_BANK = BW'(NUM_BANKS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        WAIT_VS = 2'b01,
        CAPTURE = 2'b10,
        DROP    = 2'b11
    } state_t;

    state_t               state_q, state_d;
    logic                 vs_q, href_q;
    logic [CW-1:0]        pix_cnt_q, pix_cnt_d;
    logic [SW-1:0]        sh_q, sh_d;
    logic [BANK_AW-1:0]   word_ptr_q, word_ptr_d;
    logic [BW-1:0]        bank_ptr_q, bank_ptr_d;
    logic [NUM_BANKS-1:0] full_q, full_d;
    logic                 ovf_q, ovf_d;
    logic [15:0]          frame_q, frame_d;
    logic [11:0]          line_q, line_d;
    logic [WORD_W-1:0]    pat_q, pat_d;
    logic [NUM_BANKS-1:0] we_q, we_d;
    logic [BANK_AW-1:0]   addr_q, addr_d;
    logic [WORD_W-1:0]    data_q, data_d;

    logic              vs_rise, vs_fall, href_fall, in_frame;
    logic [WORD_W-1:0] word;

    assign vs_rise   = VSYNCI & ~vs_q;
    assign vs_fall   = ~VSYNCI & vs_q;
    assign href_fall = ~HREFI & href_q;
    assign in_frame  = (state_q == CAPTURE) || (state_q == DROP);
    // Oldest pixel sits at the top of the shift register.
    assign word      = {sh_q, PIXD_i};

    always_comb begin
        state_d    = state_q;
        pix_cnt_d  = pix_cnt_q;
        sh_d       = sh_q;
        word_ptr_d = word_ptr_q;
        bank_ptr_d = bank_ptr_q;
        full_d     = full_q & ~bank_release_i;
        ovf_d      = ovf_q;
        frame_d    = frame_q;
        line_d     = line_q;
        pat_d      = pat_q;
        we_d       = '0;
        addr_d     = addr_q;
        data_d     = data_q;
        if (clr_i) begin
            state_d    = IDLE;
            pix_cnt_d  = '0;
            word_ptr_d = '0;
            bank_ptr_d = '0;
            full_d     = '0;
            ovf_d      = 1'b0;
            frame_d    = '0;
            line_d     = '0;
            pat_d      = '0;
        end else if (!enable_i) begin
            state_d   = IDLE;
            pix_cnt_d = '0;
        end else begin
            if (in_frame && href_fall && line_q != 12'hFFF)
                line_d = line_q + 12'd1;
            unique case (state_q)
                IDLE: state_d = WAIT_VS;
                WAIT_VS: begin
                    if (vs_rise) begin
                        state_d = CAPTURE;
                        frame_d = frame_q + 16'd1;
                        line_d  = '0;
                    end
                end
                CAPTURE: begin
                    if (vs_fall) begin
                        state_d   = WAIT_VS;
                        pix_cnt_d = '0;
                    end else if (HREFI && VSYNCI) begin
                        sh_d = word[SW-1:0];
                        if (pix_cnt_q == LAST_PIX) begin
                            pix_cnt_d = '0;
                            if (full_q[bank_ptr_q]) begin
                                ovf_d   = 1'b1;
                                state_d = DROP;
                            end else begin
                                for (int k = 0; k < NUM_BANKS; k++)
                                    we_d[k] = (bank_ptr_q == BW'(k));
                                addr_d     = word_ptr_q;
                                data_d     = mode_i ? pat_q : word;
                                pat_d      = pat_q + 1'b1;
                                word_ptr_d = word_ptr_q + 1'b1;
                                // Last slot: flag full (beats a release) and move on.
                                if (word_ptr_q == '1) begin
                                    full_d[bank_ptr_q] = 1'b1;
                                    bank_ptr_d = (bank_ptr_q == LAST_BANK) ?
                                                 '0 : bank_ptr_q + 1'b1;
                                end
                            end
                        end else begin
                            pix_cnt_d = pix_cnt_q + 1'b1;
                        end
                    end
                end
                DROP: if (vs_fall) state_d = WAIT_VS;
            endcase
        end
    end

    always_ff @(posedge PCLKI or posedge WBs_RST_i) begin
        if (WBs_RST_i) begin
            state_q    <= IDLE;
            vs_q       <= 1'b0;
            href_q     <= 1'b0;
            pix_cnt_q  <= '0;
            sh_q       <= '0;
            word_ptr_q <= '0;
            bank_ptr_q <= '0;
            full_q     <= '0;
            ovf_q      <= 1'b0;
            frame_q    <= '0;
            line_q     <= '0;
            pat_q      <= '0;
            we_q       <= '0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            vs_q       <= VSYNCI;
            href_q     <= HREFI;
            pix_cnt_q  <= pix_cnt_d;
            sh_q       <= sh_d;
            word_ptr_q <= word_ptr_d;
            bank_ptr_q <= bank_ptr_d;
            full_q     <= full_d;
            ovf_q      <= ovf_d;
            frame_q    <= frame_d;
            line_q     <= line_d;
            pat_q      <= pat_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
        end
    end

    assign wr_addr_o   = addr_q;
    assign wr_data_o   = data_q;
    assign wr_en_o     = we_q;
    assign bank_full_o = full_q;
    assign overflow_o  = ovf_q;
    assign frame_cnt_o = frame_q;
    assign line_cnt_o  = line_q;
    assign state_o     = state_q;
endmodule

// File: tb/tb_cam_bank_packer.sv
// Bench for cam_bank_packer: directed test-plan steps plus random
// traffic, all checked against a queue-based reference model.
module tb_cam_bank_packer;
    localparam int PW = 8;
    localparam int WW = 32;
    localparam int NB = 2;
    localparam int AW = 2;
    localparam int BY = WW / PW;
    localparam int DEPTH = 1 << AW;
    localparam int S_IDLE = 0;
    localparam int S_WAIT = 1;
    localparam int S_CAP = 2;
    localparam int S_DROP = 3;

    logic          PCLKI = 1'b0;
    logic          WBs_RST_i, VSYNCI, HREFI, enable_i, mode_i, clr_i;
    logic [PW-1:0] PIXD_i;
    logic [NB-1:0] bank_release_i;
    logic [AW-1:0] wr_addr_o;
    logic [WW-1:0] wr_data_o;
    logic [NB-1:0] wr_en_o, bank_full_o;
    logic          overflow_o;
    logic [15:0]   frame_cnt_o;
    logic [11:0]   line_cnt_o;
    logic [1:0]    state_o;

    cam_bank_packer #(
        .PIX_W(PW), .WORD_W(WW), .NUM_BANKS(NB), .BANK_AW(AW)
    ) dut (
        .PCLKI(PCLKI), .WBs_RST_i(WBs_RST_i), .VSYNCI(VSYNCI),
        .HREFI(HREFI), .PIXD_i(PIXD_i), .enable_i(enable_i),
        .mode_i(mode_i), .clr_i(clr_i), .bank_release_i(bank_release_i),
        .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o), .wr_en_o(wr_en_o),
        .bank_full_o(bank_full_o), .overflow_o(overflow_o),
        .frame_cnt_o(frame_cnt_o), .line_cnt_o(line_cnt_o),
        .state_o(state_o)
    );

    always #5 PCLKI = ~PCLKI;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    int            m_state, m_widx, m_bank, m_lines;
    logic          m_vs_prev, m_href_prev, m_ovf;
    logic [PW-1:0] m_q[$];
    logic [NB-1:0] m_full, m_we;
    logic [15:0]   m_frames;
    logic [WW-1:0] m_pat, m_data;
    logic [AW-1:0] m_addr;

    logic vs_r, hr_r;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = S_IDLE; m_widx = 0; m_bank = 0; m_lines = 0;
        m_vs_prev = 1'b0; m_href_prev = 1'b0; m_ovf = 1'b0;
        m_q.delete(); m_full = '0; m_we = '0; m_frames = '0;
        m_pat = '0; m_data = '0; m_addr = '0;
    endtask

    task automatic model_edge();
        logic rise, fall, hfall;
        logic [WW-1:0] w;
        int set_k;
        rise  = VSYNCI && !m_vs_prev;
        fall  = !VSYNCI && m_vs_prev;
        hfall = !HREFI && m_href_prev;
        set_k = -1;
        m_we  = '0;
        if (clr_i) begin
            m_state = S_IDLE; m_q.delete(); m_widx = 0; m_bank = 0;
            m_full = '0; m_ovf = 1'b0; m_frames = '0; m_lines = 0;
            m_pat = '0;
        end else begin
            if (!enable_i) begin
                m_state = S_IDLE;
                m_q.delete();
            end else begin
                if ((m_state == S_CAP || m_state == S_DROP) && hfall
                    && m_lines < 4095)
                    m_lines++;
                case (m_state)
                    S_IDLE: m_state = S_WAIT;
                    S_WAIT: if (rise) begin
                        m_state = S_CAP; m_frames++; m_lines = 0;
                    end
                    S_CAP: begin
                        if (fall) begin
                            m_state = S_WAIT; m_q.delete();
                        end else if (HREFI && VSYNCI) begin
                            m_q.push_back(PIXD_i);
                            if (m_q.size() == BY) begin
                                w = '0;
                                foreach (m_q[i]) w = (w << PW) | WW'(m_q[i]);
                                m_q.delete();
                                if (mode_i) w = m_pat;
                                if (m_full[m_bank]) begin
                                    m_ovf = 1'b1; m_state = S_DROP;
                                end else begin
                                    m_we[m_bank] = 1'b1;
                                    m_addr = AW'(m_widx);
                                    m_data = w;
                                    m_pat++;
                                    m_widx++;
                                    if (m_widx == DEPTH) begin
                                        m_widx = 0;
                                        m_full[m_bank] = 1'b1;
                                        set_k = m_bank;
                                        m_bank = (m_bank + 1) % NB;
                                    end
                                end
                            end
                        end
                    end
                    S_DROP: if (fall) m_state = S_WAIT;
                    default: ;
                endcase
            end
            for (int k = 0; k < NB; k++)
                if (bank_release_i[k] && k != set_k) m_full[k] = 1'b0;
        end
        m_vs_prev = VSYNCI;
        m_href_prev = HREFI;
    endtask

    task automatic compare_all();
        check("state", 32'(state_o), 32'(m_state));
        check("wr_en", 32'(wr_en_o), 32'(m_we));
        check("full", 32'(bank_full_o), 32'(m_full));
        check("ovf", 32'(overflow_o), 32'(m_ovf));
        check("frame", 32'(frame_cnt_o), 32'(m_frames));
        check("line", 32'(line_cnt_o), 32'(m_lines));
        if (m_we != '0) begin
            check("addr", 32'(wr_addr_o), 32'(m_addr));
            check("data", wr_data_o, m_data);
        end
    endtask

    task automatic step();
        if (WBs_RST_i) model_reset();
        else model_edge();
        @(posedge PCLKI);
        #1;
        compare_all();
    endtask

    task automatic cyc(input logic vs, input logic hr, input logic [PW-1:0] px);
        VSYNCI = vs; HREFI = hr; PIXD_i = px;
        step();
        clr_i = 1'b0;
        bank_release_i = '0;
    endtask

    task automatic start_frame();
        cyc(1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, '0);
        cyc(1'b1, 1'b0, '0);
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_addr"}, 32'(wr_addr_o), 0);
        check({tag, "_data"}, wr_data_o, 0);
        check({tag, "_wen"}, 32'(wr_en_o), 0);
        check({tag, "_full"}, 32'(bank_full_o), 0);
        check({tag, "_ovf"}, 32'(overflow_o), 0);
        check({tag, "_frame"}, 32'(frame_cnt_o), 0);
        check({tag, "_line"}, 32'(line_cnt_o), 0);
        check({tag, "_state"}, 32'(state_o), 0);
    endtask

    initial begin
        WBs_RST_i = 1'b1; VSYNCI = 1'b0; HREFI = 1'b0; PIXD_i = '0;
        enable_i = 1'b0; mode_i = 1'b0; clr_i = 1'b0;
        bank_release_i = '0; vs_r = 1'b0; hr_r = 1'b0;
        model_reset();
        step();
        step();
        check_reset_outs("rst");
        WBs_RST_i = 1'b0;

        // packing order and first write
        enable_i = 1'b1;
        start_frame();
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, 1'b1, PW'(i * 8'h11));
            if (i == 4) begin
                check("tp1_wen", 32'(wr_en_o), 32'h1);
                check("tp1_addr", 32'(wr_addr_o), 0);
                check("tp1_data", wr_data_o, 32'h11223344);
            end
        end
        cyc(1'b1, 1'b0, '0);
        check("tp1_line", 32'(line_cnt_o), 1);
        cyc(1'b0, 1'b0, '0);
        clr_i = 1'b1;
        cyc(1'b0, 1'b0, '0);
        check("clr_frame", 32'(frame_cnt_o), 0);

        // pattern mode fills both banks then overflows
        mode_i = 1'b1;
        start_frame();
        for (int w = 0; w < 9; w++) begin
            for (int b = 0; b < BY; b++) cyc(1'b1, 1'b1, PW'($urandom));
            if (w < 8) begin
                check("tp2_data", wr_data_o, 32'(w));
                check("tp2_wen", 32'(wr_en_o), (w < 4) ? 1 : 2);
            end
            if (w == 3) check("tp2_full3", 32'(bank_full_o), 1);
            if (w == 7) check("tp2_full7", 32'(bank_full_o), 3);
            if (w == 8) begin
                check("tp2_drop_wen", 32'(wr_en_o), 0);
                check("tp2_ovf", 32'(overflow_o), 1);
                check("tp2_state", 32'(state_o), 3);
            end
        end
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, PW'($urandom));
        cyc(1'b1, 1'b0, '0);
        cyc(1'b0, 1'b0, '0);

        // release bank 0 and resume
        bank_release_i = 2'b01;
        cyc(1'b0, 1'b0, '0);
        check("tp3_full", 32'(bank_full_o), 2);
        start_frame();
        for (int b = 0; b < BY; b++) cyc(1'b1, 1'b1, PW'($urandom));
        check("tp3_data", wr_data_o, 8);
        check("tp3_addr", 32'(wr_addr_o), 0);
        check("tp3_wen", 32'(wr_en_o), 1);
        check("tp3_ovf", 32'(overflow_o), 1);

        // set and release of the same bank in one cycle
        for (int i = 0; i < 3 * BY; i++) begin
            if (i == 3 * BY - 1) bank_release_i = 2'b01;
            cyc(1'b1, 1'b1, PW'($urandom));
        end
        check("tp4_full", 32'(bank_full_o), 3);
        cyc(1'b1, 1'b0, '0);
        cyc(1'b0, 1'b0, '0);
        bank_release_i = 2'b11;
        cyc(1'b0, 1'b0, '0);
        bank_release_i = 2'b01;
        cyc(1'b0, 1'b0, '0);
        check("tp4_nonfull_rel", 32'(bank_full_o), 0);

        // partial word at frame end is discarded
        mode_i = 1'b0;
        start_frame();
        cyc(1'b1, 1'b1, 8'hE1);
        cyc(1'b1, 1'b1, 8'hE2);
        cyc(1'b0, 1'b0, '0);
        start_frame();
        cyc(1'b1, 1'b1, 8'hA1);
        cyc(1'b1, 1'b1, 8'hA2);
        cyc(1'b1, 1'b1, 8'hA3);
        cyc(1'b1, 1'b1, 8'hA4);
        check("tp5_data", wr_data_o, 32'hA1A2A3A4);
        check("tp5_wen", 32'(wr_en_o), 2);
        cyc(1'b1, 1'b0, '0);
        check("tp5_line", 32'(line_cnt_o), 1);
        check("tp5_frame", 32'(frame_cnt_o), 4);
        cyc(1'b0, 1'b0, '0);

        // enable dropped mid-word
        start_frame();
        cyc(1'b1, 1'b1, 8'h01);
        cyc(1'b1, 1'b1, 8'h02);
        enable_i = 1'b0;
        cyc(1'b1, 1'b1, 8'h03);
        check("tp6_state", 32'(state_o), 0);
        check("tp6_wen", 32'(wr_en_o), 0);
        cyc(1'b1, 1'b1, 8'h04);
        check("tp6_wen2", 32'(wr_en_o), 0);
        enable_i = 1'b1;
        cyc(1'b1, 1'b0, '0);
        cyc(1'b0, 1'b0, '0);

        // asynchronous reset mid-word
        start_frame();
        cyc(1'b1, 1'b1, 8'h55);
        cyc(1'b1, 1'b1, 8'h66);
        WBs_RST_i = 1'b1;
        #2;
        check_reset_outs("arst");
        model_reset();
        cyc(1'b0, 1'b0, '0);
        WBs_RST_i = 1'b0;

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(39) == 0) begin
                vs_r = ~vs_r;
                mode_i = 1'($urandom_range(1));
            end
            if ($urandom_range(5) == 0) hr_r = ~hr_r;
            for (int k = 0; k < NB; k++)
                if ($urandom_range(24) == 0) bank_release_i[k] = 1'b1;
            if ($urandom_range(499) == 0) clr_i = 1'b1;
            enable_i = ($urandom_range(299) != 0);
            cyc(vs_r, hr_r, PW'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
